// File: rtl/dmem_resp.sv
// Data memory with registered, one-cycle load response and byte-lane stores.
// Define DMEM_MISALIGN_CHECK_EN to reject misaligned H/HU/W accesses with err.
module dmem_resp #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] mem_addr,
    input  logic [31:0] write_data,
    input  logic        load_en,
    input  logic        store_en,
    input  logic [2:0]  size,
    output logic [31:0] mem_data,
    output logic        data_valid,
    output logic        stall,
    output logic        err
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RESP = 1'b1;

    logic [0:0]            state;
    logic [31:0]           ram [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] idx;
    logic                  legal;
    logic                  misal;
    logic                  idle;
    logic                  do_store;
    logic                  do_load;
    logic                  bad;
    logic [1:0]            off;
    logic [3:0]            be;
    logic [31:0]           wdata;
    logic [31:0]           rdata;
    logic [2:0]            size_q;
    logic [1:0]            off_q;
    logic [7:0]            byte_s;
    logic [15:0]           half_s;
    logic [31:0]           ext;
    logic                  unused_addr;

    assign idx         = mem_addr[DEPTH_LOG2+1:2];
    assign unused_addr = ^mem_addr[31:DEPTH_LOG2+2];

    always_comb begin
        unique case (size)
            3'b000, 3'b001, 3'b010,
            3'b100, 3'b101: legal = 1'b1;
            default:        legal = 1'b0;
        endcase
    end

`ifdef DMEM_MISALIGN_CHECK_EN
    assign misal = (size[1:0] == 2'b01 && mem_addr[0]) ||
                   (size == 3'b010 && mem_addr[1:0] != 2'b00);
`else
    assign misal = 1'b0;
`endif

    // Low address bits forced to natural alignment for H and W
    always_comb begin
        unique case (size[1:0])
            2'b00:   off = mem_addr[1:0];
            2'b01:   off = {mem_addr[1], 1'b0};
            default: off = 2'b00;
        endcase
    end

    always_comb begin
        unique case (size[1:0])
            2'b00: begin
                be    = 4'b0001 << off;
                wdata = {4{write_data[7:0]}};
            end
            2'b01: begin
                be    = 4'b0011 << off;
                wdata = {2{write_data[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = write_data;
            end
        endcase
    end

    assign idle     = (state == IDLE);
    assign do_store = idle && store_en && legal && !misal;
    assign do_load  = idle && load_en && !store_en && legal && !misal;
    assign bad      = idle && (load_en || store_en) &&
                      (!legal || misal || (load_en && store_en));

    assign stall = do_load && rst_n;

    // RAM and read register are not reset
    always_ff @(posedge clk) begin
        if (do_store) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) ram[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (do_load) rdata <= ram[idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            size_q <= 3'b000;
            off_q  <= 2'b00;
            err    <= 1'b0;
        end else begin
            err <= bad;
            unique case (state)
                IDLE: begin
                    if (do_load) begin
                        state  <= RESP;
                        size_q <= size;
                        off_q  <= off;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        byte_s = rdata[8*off_q +: 8];
        half_s = off_q[1] ? rdata[31:16] : rdata[15:0];
        unique case (size_q)
            3'b000:  ext = {{24{byte_s[7]}}, byte_s};
            3'b100:  ext = {24'b0, byte_s};
            3'b001:  ext = {{16{half_s[15]}}, half_s};
            3'b101:  ext = {16'b0, half_s};
            default: ext = rdata;
        endcase
    end

    assign data_valid = (state == RESP);
    assign mem_data   = data_valid ? ext : 32'h0;

endmodule

// File: tb/tb_dmem_resp.sv
// Scoreboarded bench for dmem_resp: loads push expected data, the
// negedge monitor pops and compares whenever data_valid is seen.
module tb_dmem_resp;

    localparam logic [2:0] B  = 3'b000;
    localparam logic [2:0] H  = 3'b001;
    localparam logic [2:0] W  = 3'b010;
    localparam logic [2:0] BU = 3'b100;
    localparam logic [2:0] HU = 3'b101;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] mem_addr;
    logic [31:0] write_data;
    logic        load_en;
    logic        store_en;
    logic [2:0]  size;
    logic [31:0] mem_data;
    logic        data_valid;
    logic        stall;
    logic        err;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] sb [$];

    dmem_resp #(.DEPTH_LOG2(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_addr   (mem_addr),
        .write_data (write_data),
        .load_en    (load_en),
        .store_en   (store_en),
        .size       (size),
        .mem_data   (mem_data),
        .data_valid (data_valid),
        .stall      (stall),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (data_valid) begin
            if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
            else chk("load_data", mem_data, sb.pop_front());
        end
    end

    task automatic req(input logic ld, input logic st,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [2:0] sz, input logic exp_ld,
                       input logic exp_er, input logic [31:0] exp_d);
        @(negedge clk);
        load_en    = ld;
        store_en   = st;
        mem_addr   = a;
        write_data = wd;
        size       = sz;
        #1;
        chk("stall", {31'b0, stall}, {31'b0, exp_ld});
        if (exp_ld) sb.push_back(exp_d);
        @(posedge clk);
        #1;
        load_en  = 1'b0;
        store_en = 1'b0;
        chk("err", {31'b0, err}, {31'b0, exp_er});
        chk("valid", {31'b0, data_valid}, {31'b0, exp_ld});
        if (exp_ld) begin
            @(posedge clk);
            #1;
            chk("valid_off", {31'b0, data_valid}, 32'd0);
            chk("data_zero", mem_data, 32'd0);
            chk("err_off", {31'b0, err}, 32'd0);
        end
    endtask

    task automatic st_op(input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] sz);
        req(1'b0, 1'b1, a, d, sz, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic ld_op(input logic [31:0] a, input logic [2:0] sz,
                         input logic [31:0] exp);
        req(1'b1, 1'b0, a, 32'h0, sz, 1'b1, 1'b0, exp);
    endtask

    initial begin
        rst_n      = 1'b0;
        load_en    = 1'b1;
        store_en   = 1'b0;
        mem_addr   = 32'h10;
        write_data = 32'h0;
        size       = W;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {31'b0, data_valid}, 32'd0);
        chk("rst_data", mem_data, 32'd0);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        @(negedge clk);
        load_en = 1'b0;
        rst_n   = 1'b1;

        st_op(32'h10, 32'hDEADBEEF, W);
        ld_op(32'h10, W, 32'hDEADBEEF);

        st_op(32'h10, 32'h0, W);
        st_op(32'h13, 32'h80, B);
        ld_op(32'h13, B, 32'hFFFFFF80);
        ld_op(32'h13, BU, 32'h00000080);
        ld_op(32'h10, W, 32'h80000000);
        st_op(32'h11, 32'hAA7F, B);
        ld_op(32'h11, B, 32'h0000007F);
        ld_op(32'h10, W, 32'h80007F00);

        st_op(32'h20, 32'h0, W);
        st_op(32'h22, 32'h1234, H);
        ld_op(32'h22, HU, 32'h00001234);
        ld_op(32'h20, W, 32'h12340000);
        st_op(32'h20, 32'h9876, H);
        ld_op(32'h20, H, 32'hFFFF9876);
        ld_op(32'h20, HU, 32'h00009876);

        st_op(32'h4, 32'hCAFEF00D, W);
        ld_op(32'h1004, W, 32'hCAFEF00D);

        st_op(32'h30, 32'h0, W);
        req(1'b1, 1'b1, 32'h30, 32'h5, W, 1'b0, 1'b1, 32'h0);
        ld_op(32'h30, W, 32'h00000005);

        req(1'b1, 1'b0, 32'h10, 32'h0, 3'b011, 1'b0, 1'b1, 32'h0);
        req(1'b0, 1'b1, 32'h10, 32'hFFFFFFFF, 3'b110, 1'b0, 1'b1, 32'h0);
        req(1'b0, 1'b1, 32'h10, 32'hFFFFFFFF, 3'b111, 1'b0, 1'b1, 32'h0);
        ld_op(32'h10, W, 32'h80007F00);

`ifdef DMEM_MISALIGN_CHECK_EN
        req(1'b1, 1'b0, 32'h12, 32'h0, W, 1'b0, 1'b1, 32'h0);
        req(1'b0, 1'b1, 32'h21, 32'hBEEF, H, 1'b0, 1'b1, 32'h0);
        ld_op(32'h20, W, 32'h12349876);
`else
        ld_op(32'h12, W, 32'h80007F00);
        st_op(32'h23, 32'hBEEF, H);
        ld_op(32'h20, W, 32'hBEEF9876);
`endif

        // Store presented while the load response is on the bus is ignored
        st_op(32'h40, 32'h11111111, W);
        @(negedge clk);
        load_en  = 1'b1;
        mem_addr = 32'h40;
        size     = W;
        sb.push_back(32'h11111111);
        @(posedge clk);
        #1;
        load_en    = 1'b0;
        store_en   = 1'b1;
        write_data = 32'h22222222;
        #1;
        chk("resp_stall", {31'b0, stall}, 32'd0);
        @(posedge clk);
        #1;
        store_en = 1'b0;
        chk("resp_err", {31'b0, err}, 32'd0);
        ld_op(32'h40, W, 32'h11111111);

        // Reset while a response is pending drops it at once
        @(negedge clk);
        load_en  = 1'b1;
        mem_addr = 32'h4;
        size     = W;
        @(posedge clk);
        #1;
        load_en = 1'b0;
        chk("pre_rst_valid", {31'b0, data_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_resp_valid", {31'b0, data_valid}, 32'd0);
        chk("rst_resp_data", mem_data, 32'd0);
        chk("rst_resp_stall", {31'b0, stall}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ld_op(32'h4, W, 32'hCAFEF00D);

        repeat (2) @(posedge clk);
        chk("sb_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
